// File: rtl/trig_pulse_gen.sv
// Trigger pulse generator: turns one-cycle requests into registered
// pulses of programmable width, each followed by a programmable low gap.
module trig_pulse_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    output logic             pulse_out,
    output logic             busy,
    output logic             pend,
    output logic             drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] wload;
    logic [CNT_W-1:0] gload;

    // Reload values: a zero field behaves like one cycle.
    always_comb begin
        wload = (width == '0) ? '0 : width - 1'b1;
        gload = (gap == '0) ? '0 : gap - 1'b1;
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_in) begin
                    state_d = HIGH;
                    pulse_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = wload;
                end
            end
            HIGH: begin
                pulse_d = 1'b1;
                busy_d  = 1'b1;
                if (trig_in) begin
                    if (pend_q) drop_d = 1'b1;
                    else        pend_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = GAP;
                    pulse_d = 1'b0;
                    cnt_d   = gload;
                end
            end
            GAP: begin
                pulse_d = 1'b0;
                busy_d  = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (trig_in) begin
                        if (pend_q) drop_d = 1'b1;
                        else        pend_d = 1'b1;
                    end
                end else if (pend_q || trig_in) begin
                    // Serve the queued request first; a new one takes its slot.
                    state_d = HIGH;
                    pulse_d = 1'b1;
                    cnt_d   = wload;
                    pend_d  = pend_q ? trig_in : 1'b0;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                pend_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign pend      = pend_q;
    assign drop      = drop_q;

endmodule
